cp0_core: RTL and testbench
===========================

CP0_CORE -- requirements
Module: cp0_core

Interface
REQ-001 SHALL have parameter EXT_INT_W, default 6, number of external interrupt lines (legal 1..6).
REQ-002 SHALL have parameter TICK_DIV, default 2, clk cycles per Count increment (legal >=1).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on ext_int_in (legal >=1).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: ext_int_in in EXT_INT_W async interrupt lines; wb_ex in 1 exception commit; wb_excode in 5 cause code; wb_badvaddr in 32 faulting address; wb_bd in 1 delay-slot flag; wb_pc in 32 excepting PC.
REQ-006 SHALL have ports: mtc0_we in 1 write enable; c0_waddr in 5 write address; c0_wdata in 32 write data; eret_flush in 1 ERET commit; c0_raddr in 5 read address.
REQ-007 SHALL have outputs: rdata out 32 read data; epc_out out 32 EPC value; status_exl out 1 EXL bit; int_req out 1 registered interrupt request to pipeline.

Function
REQ-008 Register map SHALL be BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14; rdata combinational from c0_raddr, other addresses read 0.
REQ-009 Status read SHALL be {9'b0, BEV=1, 6'b0, IM[7:0], 6'b0, EXL, IE}; Cause read SHALL be {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b0}.
REQ-010 Same-cycle priority SHALL be wb_ex > eret_flush > mtc0_we; mtc0_we with wb_ex high SHALL be ignored entirely.
REQ-011 wb_ex SHALL set EXL=1 and ExcCode=wb_excode; BD and EPC update only if EXL was 0; EPC=wb_bd ? wb_pc-4 : wb_pc (32-bit wrap).
REQ-012 wb_ex with wb_excode 4 (AdEL) or 5 (AdES) SHALL load BadVAddr=wb_badvaddr; other codes leave it unchanged.
REQ-013 eret_flush SHALL clear EXL; mtc0 Status SHALL write IM=wdata[15:8], EXL=wdata[1], IE=wdata[0].
REQ-014 mtc0 Cause SHALL write only IP[1:0]=wdata[9:8]; mtc0 EPC SHALL write EPC; BadVAddr SHALL be read-only.
REQ-015 ext_int_in SHALL pass a SYNC_STAGES flop chain; IP[6:2] and IP[7] SHALL register synced lines zero-extended to 6 bits, IP[7] ORed with TI; latency ext pin -> IP = SYNC_STAGES+1 cycles.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and wrap; Count SHALL increment (wrap 0xFFFFFFFF->0) in the cycle prescaler==TICK_DIV-1.
REQ-017 mtc0 Count SHALL load Count and clear prescaler; write beats same-cycle increment.
REQ-018 TI SHALL set when Count==Compare (registered values), cleared by mtc0 Compare; clear beats same-cycle set.
REQ-019 int_req SHALL be registered: next cycle = IE & ~EXL & |(IP & IM); status_exl and epc_out SHALL be the register values.

Reset
REQ-020 Reset SHALL asynchronously clear Count, Compare, prescaler, IM, EXL, IE, BD, TI, IP, ExcCode, EPC, BadVAddr, sync chain and int_req to 0.
REQ-021 Reset asserted mid-operation SHALL abandon any pending update; first post-reset edge SHALL behave as from power-up.

Configuration
REQ-022 Macro CP0_TIMER_EN defined: Count, Compare, prescaler, TI implemented per REQ-016..018.
REQ-023 CP0_TIMER_EN undefined: no timer flops; Count/Compare read 0, writes ignored, TI reads 0, IP[7] = synced ext line only.

Structure
REQ-024 Shared package cp0_pkg SHALL hold CR_* register addresses, EX_ADEL/EX_ADES codes and Status/Cause field bit positions.
REQ-025 Synchronizer SHALL be sub-module cp0_int_sync (parameters WIDTH, STAGES, async reset to 0).

Verification
REQ-026 Reset, then read Status -> 0x0040_0000; Cause, EPC, Count -> 0.
REQ-027 wb_ex excode=4, bd=1, pc=0xBFC0_0104, badvaddr=0x1234_5671 -> EPC=0xBFC0_0100, BadVAddr=0x1234_5671, Cause=0x8000_0010, EXL=1; second wb_ex with pc=0x200 -> EPC unchanged.
REQ-028 TICK_DIV=2: mtc0 Compare=5, Count=0 -> Count reaches 5 after 10 cycles, TI=1, Cause.IP[7]=1; mtc0 Compare=9 -> TI=0 next cycle.
REQ-029 Status=0x0000_0401, pulse ext_int_in[0] -> IP[2]=1 after SYNC_STAGES+1 cycles, int_req=1 one cycle later; set EXL via wb_ex -> int_req=0.
REQ-030 Same cycle wb_ex, eret_flush and mtc0 Status=0 -> EXL=1, IE/IM unchanged; mtc0 Count=0xFFFF_FFFF then increment -> Count=0.
REQ-031 Build without CP0_TIMER_EN: mtc0 Count=7 -> Count reads 0, TI never sets.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register addresses, exception codes used by the
// core, and the bit positions of the Status/Cause fields.
package cp0_pkg;

    // Register addresses (c0_raddr / c0_waddr)
    localparam logic [4:0] CR_BADVADDR = 5'd8;
    localparam logic [4:0] CR_COUNT    = 5'd9;
    localparam logic [4:0] CR_COMPARE  = 5'd11;
    localparam logic [4:0] CR_STATUS   = 5'd12;
    localparam logic [4:0] CR_CAUSE    = 5'd13;
    localparam logic [4:0] CR_EPC      = 5'd14;

    // Exception codes that capture BadVAddr
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;

    // Status field positions
    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_BEV   = 22;

    // Cause field positions
    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_IP_LO  = 8;
    localparam int unsigned CA_TI     = 30;
    localparam int unsigned CA_BD     = 31;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EX_ADEL) || (code == EX_ADES);
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Multi-flop synchronizer for asynchronous interrupt lines.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (chain clears to 0)
//   din         - asynchronous inputs, WIDTH bits
//   dout        - synchronized outputs, STAGES cycles after din
module cp0_int_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/cp0_core.sv
// CP0 system-control coprocessor: Status, Cause, EPC, BadVAddr, and an
// optional Count/Compare timer (enabled by defining CP0_TIMER_EN).
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   ext_int_in             - asynchronous external interrupt lines
//   wb_ex/wb_excode/wb_badvaddr/wb_bd/wb_pc - exception commit from writeback
//   mtc0_we/c0_waddr/c0_wdata - CP0 register write
//   eret_flush             - ERET commit (clears EXL)
//   c0_raddr / rdata       - combinational register read
//   epc_out, status_exl    - EPC and EXL register values
//   int_req                - registered interrupt request to the pipeline
module cp0_core
    import cp0_pkg::*;
#(
    parameter int unsigned EXT_INT_W   = 6,
    parameter int unsigned TICK_DIV    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EXT_INT_W-1:0] ext_int_in,
    input  logic                 wb_ex,
    input  logic [4:0]           wb_excode,
    input  logic [31:0]          wb_badvaddr,
    input  logic                 wb_bd,
    input  logic [31:0]          wb_pc,
    input  logic                 mtc0_we,
    input  logic [4:0]           c0_waddr,
    input  logic [31:0]          c0_wdata,
    input  logic                 eret_flush,
    input  logic [4:0]           c0_raddr,
    output logic [31:0]          rdata,
    output logic [31:0]          epc_out,
    output logic                 status_exl,
    output logic                 int_req
);

    // An exception in writeback swallows any same-cycle mtc0 entirely.
    logic cp_write;
    assign cp_write = mtc0_we & ~wb_ex;

    // ---------------------------------------------------------------
    // Interrupt synchronization
    // ---------------------------------------------------------------
    logic [EXT_INT_W-1:0] ext_sync;
    logic [5:0]           ext6;

    cp0_int_sync #(
        .WIDTH  (EXT_INT_W),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ext_int_in),
        .dout  (ext_sync)
    );

    always_comb begin
        ext6 = '0;
        ext6[EXT_INT_W-1:0] = ext_sync;
    end

    // ---------------------------------------------------------------
    // Timer
    // ---------------------------------------------------------------
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        ti;

`ifdef CP0_TIMER_EN
    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic               ti_q, ti_d;

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
        // A Count write overrides the tick and restarts the prescaler.
        if (cp_write && (c0_waddr == CR_COUNT)) begin
            count_d = c0_wdata;
            presc_d = '0;
        end

        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
        // Compare write acknowledges the timer interrupt, even on a match.
        if (cp_write && (c0_waddr == CR_COMPARE)) begin
            compare_d = c0_wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_val   = count_q;
    assign compare_val = compare_q;
    assign ti          = ti_q;
`else
    logic unused_tick_div;
    assign unused_tick_div = ^TICK_DIV;

    assign count_val   = '0;
    assign compare_val = '0;
    assign ti          = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Status / Cause / EPC / BadVAddr
    // ---------------------------------------------------------------
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  excode_q, excode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q;
    logic        int_req_q, int_req_d;
    logic [7:0]  ip;

    // IP[7] shares the top hardware line with the timer interrupt.
    assign ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        excode_d   = excode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_sw_d    = ip_sw_q;
        int_req_d  = ie_q & ~exl_q & (|(ip & im_q));

        if (wb_ex) begin
            exl_d    = 1'b1;
            excode_d = wb_excode;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                bd_d  = wb_bd;
                epc_d = wb_bd ? (wb_pc - 32'd4) : wb_pc;
            end
            if (is_addr_exc(wb_excode)) begin
                badvaddr_d = wb_badvaddr;
            end
        end else begin
            if (mtc0_we) begin
                unique case (c0_waddr)
                    CR_STATUS: begin
                        im_d  = c0_wdata[ST_IM_LO +: 8];
                        exl_d = c0_wdata[ST_EXL];
                        ie_d  = c0_wdata[ST_IE];
                    end
                    CR_CAUSE: ip_sw_d = c0_wdata[CA_IP_LO +: 2];
                    CR_EPC:   epc_d   = c0_wdata;
                    default:  ;
                endcase
            end
            if (eret_flush) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            excode_q   <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            int_req_q  <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            excode_q   <= excode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ext6;
            int_req_q  <= int_req_d;
        end
    end

    // ---------------------------------------------------------------
    // Read mux and outputs
    // ---------------------------------------------------------------
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    always_comb begin
        status_rd                   = '0;
        status_rd[ST_BEV]           = 1'b1;
        status_rd[ST_IM_LO +: 8]    = im_q;
        status_rd[ST_EXL]           = exl_q;
        status_rd[ST_IE]            = ie_q;

        cause_rd                    = '0;
        cause_rd[CA_BD]             = bd_q;
        cause_rd[CA_TI]             = ti;
        cause_rd[CA_IP_LO +: 8]     = ip;
        cause_rd[CA_EXC_LO +: 5]    = excode_q;
    end

    always_comb begin
        rdata = '0;
        unique case (c0_raddr)
            CR_BADVADDR: rdata = badvaddr_q;
            CR_COUNT:    rdata = count_val;
            CR_COMPARE:  rdata = compare_val;
            CR_STATUS:   rdata = status_rd;
            CR_CAUSE:    rdata = cause_rd;
            CR_EPC:      rdata = epc_q;
            default:     rdata = '0;
        endcase
    end

    assign epc_out    = epc_q;
    assign status_exl = exl_q;
    assign int_req    = int_req_q;

endmodule

// File: tb/tb_cp0_core.sv
// Bench for cp0_core: register write/read table, directed sequences for
// exceptions, timer, interrupts, priority and reset, then random traffic
// against a behavioural model. Timer checks follow CP0_TIMER_EN.
module tb_cp0_core;

    localparam int unsigned EXT_INT_W   = 6;
    localparam int unsigned TICK_DIV    = 2;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [EXT_INT_W-1:0] ext_int_in = '0;
    logic                 wb_ex = 1'b0;
    logic [4:0]           wb_excode = '0;
    logic [31:0]          wb_badvaddr = '0;
    logic                 wb_bd = 1'b0;
    logic [31:0]          wb_pc = '0;
    logic                 mtc0_we = 1'b0;
    logic [4:0]           c0_waddr = '0;
    logic [31:0]          c0_wdata = '0;
    logic                 eret_flush = 1'b0;
    logic [4:0]           c0_raddr = '0;
    logic [31:0]          rdata;
    logic [31:0]          epc_out;
    logic                 status_exl;
    logic                 int_req;

    always #5 clk = ~clk;

    cp0_core #(
        .EXT_INT_W   (EXT_INT_W),
        .TICK_DIV    (TICK_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_int_in  (ext_int_in),
        .wb_ex       (wb_ex),
        .wb_excode   (wb_excode),
        .wb_badvaddr (wb_badvaddr),
        .wb_bd       (wb_bd),
        .wb_pc       (wb_pc),
        .mtc0_we     (mtc0_we),
        .c0_waddr    (c0_waddr),
        .c0_wdata    (c0_wdata),
        .eret_flush  (eret_flush),
        .c0_raddr    (c0_raddr),
        .rdata       (rdata),
        .epc_out     (epc_out),
        .status_exl  (status_exl),
        .int_req     (int_req)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]   m_base;     // Count value at the last load
    int unsigned m_age;      // cycles since that load
    bit [31:0]   m_compare, m_epc, m_bad;
    bit          m_ti, m_ie, m_exl, m_bd, m_int_req;
    bit [7:0]    m_im;
    bit [1:0]    m_ip_sw;
    bit [4:0]    m_excode;
    bit [5:0]    m_ip_hw;
    bit [5:0]    m_delay[$]; // ext samples in flight to IP

    function automatic bit [31:0] model_count();
        return m_base + 32'(m_age / TICK_DIV);
    endfunction

    function automatic bit [7:0] model_ip();
        return {m_ip_hw[5] | m_ti, m_ip_hw[4:0], m_ip_sw};
    endfunction

    function automatic bit [31:0] model_read(input bit [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return model_count();
            5'd11:   return m_compare;
            5'd12:   return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13:   return {m_bd, m_ti, 14'b0, model_ip(), 1'b0, m_excode, 2'b0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_base = 0; m_age = 0; m_compare = 0; m_epc = 0; m_bad = 0;
        m_ti = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_int_req = 0;
        m_im = 0; m_ip_sw = 0; m_excode = 0; m_ip_hw = 0;
        m_delay = {};
        repeat (SYNC_STAGES) m_delay.push_front(6'h0);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit         wr;
        bit [31:0]  cnt;
        bit         nxt_int;
        wr      = mtc0_we && !wb_ex;
        cnt     = model_count();
        nxt_int = m_ie && !m_exl && ((model_ip() & m_im) != 8'h00);
`ifdef CP0_TIMER_EN
        if (cnt == m_compare) m_ti = 1'b1;
        if (wr && c0_waddr == 5'd11) begin
            m_compare = c0_wdata;
            m_ti = 1'b0;
        end
        if (wr && c0_waddr == 5'd9) begin
            m_base = c0_wdata;
            m_age = 0;
        end else begin
            m_age++;
        end
`else
        cnt = 0;
`endif
        m_delay.push_front(6'(ext_int_in));
        m_ip_hw = m_delay.pop_back();
        if (wb_ex) begin
            if (!m_exl) begin
                m_bd  = wb_bd;
                m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
            end
            m_exl = 1'b1;
            m_excode = wb_excode;
            if (wb_excode == 5'd4 || wb_excode == 5'd5) m_bad = wb_badvaddr;
        end else if (eret_flush) begin
            m_exl = 1'b0;
        end else if (mtc0_we) begin
            case (c0_waddr)
                5'd12: begin
                    m_im = c0_wdata[15:8]; m_exl = c0_wdata[1]; m_ie = c0_wdata[0];
                end
                5'd13:   m_ip_sw = c0_wdata[9:8];
                5'd14:   m_epc = c0_wdata;
                default: ;
            endcase
        end
        m_int_req = nxt_int;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        c0_raddr = a;
        #1;
        d = rdata;
    endtask

    task automatic check_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; c0_waddr = a; c0_wdata = d;
        tick();
        mtc0_we = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                       input logic [31:0] bad);
        wb_ex = 1'b1; wb_excode = code; wb_bd = bd; wb_pc = pc; wb_badvaddr = bad;
        tick();
        wb_ex = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] d;
        int unsigned r;

        vecs[0]  = '{"status_all1",  5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
        vecs[1]  = '{"status_a501",  5'd12, 32'h0000_A501, 5'd12, 32'h0040_A501};
        vecs[2]  = '{"status_zero",  5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
        vecs[3]  = '{"cause_all1",   5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        vecs[4]  = '{"cause_ip0",    5'd13, 32'h0000_0100, 5'd13, 32'h0000_0100};
        vecs[5]  = '{"cause_zero",   5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
        vecs[6]  = '{"epc_wr",       5'd14, 32'hDEAD_BEEF, 5'd14, 32'hDEAD_BEEF};
        vecs[7]  = '{"badvaddr_ro",  5'd8,  32'hFFFF_FFFF, 5'd8,  32'h0000_0000};
        vecs[8]  = '{"compare_wr",   5'd11, 32'h1234_5678, 5'd11, TIMER ? 32'h1234_5678 : 32'h0};
        vecs[9]  = '{"count_wr",     5'd9,  32'h0000_0100, 5'd9,  TIMER ? 32'h0000_0100 : 32'h0};
        vecs[10] = '{"unmapped",     5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
        vecs[11] = '{"epc_wr2",      5'd14, 32'h0000_0004, 5'd14, 32'h0000_0004};

        // ---- reset ----
        model_reset();
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_rd("rst_status", 5'd12, 32'h0040_0000);
        check_rd("rst_cause", 5'd13, 32'h0);
        check_rd("rst_epc", 5'd14, 32'h0);
        check_rd("rst_count", 5'd9, 32'h0);
        check("rst_int_req", {31'b0, int_req}, 32'h0);
        check("rst_exl", {31'b0, status_exl}, 32'h0);
        reset = 1'b0;

        // Park Compare far away so TI stays clear during the table.
        mtc0(5'd11, 32'hFFFF_0000);

        // ---- register table ----
        for (int i = 0; i < 12; i++) begin
            mtc0(vecs[i].waddr, vecs[i].wdata);
            check_rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end
        check("epc_out_tbl", epc_out, 32'h0000_0004);

        // ---- exception entry, nested exception ----
        exc(5'd4, 1'b1, 32'hBFC0_0104, 32'h1234_5671);
        check_rd("exc_epc", 5'd14, 32'hBFC0_0100);
        check_rd("exc_badv", 5'd8, 32'h1234_5671);
        check_rd("exc_cause", 5'd13, 32'h8000_0010);
        check("exc_epc_out", epc_out, 32'hBFC0_0100);
        check("exc_exl", {31'b0, status_exl}, 32'h1);
        exc(5'd0, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF);
        check_rd("nest_epc", 5'd14, 32'hBFC0_0100);
        check_rd("nest_badv", 5'd8, 32'h1234_5671);
        check_rd("nest_cause", 5'd13, 32'h8000_0000);
        eret_flush = 1'b1;
        tick();
        eret_flush = 1'b0;
        check("eret_exl", {31'b0, status_exl}, 32'h0);

        // ---- timer ----
`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (9) tick();
        check_rd("tmr_cnt9", 5'd9, 32'd4);
        tick();
        check_rd("tmr_cnt10", 5'd9, 32'd5);
        check_rd("tmr_ti_pre", 5'd13, 32'h8000_0000);
        tick();
        check_rd("tmr_ti_set", 5'd13, 32'hC000_8000);
        mtc0(5'd11, 32'd9);
        check_rd("tmr_ti_clr", 5'd13, 32'h8000_0000);
        mtc0(5'd9, 32'hFFFF_FFFF);
        check_rd("tmr_wrap0", 5'd9, 32'hFFFF_FFFF);
        tick();
        check_rd("tmr_wrap1", 5'd9, 32'hFFFF_FFFF);
        tick();
        check_rd("tmr_wrap2", 5'd9, 32'h0);
`else
        mtc0(5'd9, 32'd7);
        check_rd("notmr_cnt", 5'd9, 32'h0);
        mtc0(5'd11, 32'd0);
        repeat (5) tick();
        check_rd("notmr_ti", 5'd13, 32'h8000_0000);
`endif

        // ---- external interrupt path ----
        mtc0(5'd11, 32'hFFFF_0000);
        mtc0(5'd12, 32'h0000_0401);
        ext_int_in = 6'b000001;
        repeat (SYNC_STAGES) tick();
        rd(5'd13, d);
        check("ip2_early", {31'b0, d[10]}, 32'h0);
        tick();
        rd(5'd13, d);
        check("ip2_set", {31'b0, d[10]}, 32'h1);
        check("int_req_early", {31'b0, int_req}, 32'h0);
        tick();
        check("int_req_set", {31'b0, int_req}, 32'h1);
        exc(5'd0, 1'b0, 32'h0000_0300, 32'h0);
        check("int_exl", {31'b0, status_exl}, 32'h1);
        tick();
        check("int_req_masked", {31'b0, int_req}, 32'h0);
        ext_int_in = '0;

        // ---- same-cycle priority ----
        eret_flush = 1'b1;
        tick();
        eret_flush = 1'b0;
        mtc0(5'd12, 32'h0000_FF01);
        wb_ex = 1'b1; wb_excode = 5'd5; wb_bd = 1'b0; wb_pc = 32'h0000_1000;
        wb_badvaddr = 32'hCAFE_0000;
        eret_flush = 1'b1;
        mtc0_we = 1'b1; c0_waddr = 5'd12; c0_wdata = 32'h0;
        tick();
        wb_ex = 1'b0; eret_flush = 1'b0; mtc0_we = 1'b0;
        check_rd("prio_status", 5'd12, 32'h0040_FF03);
        check_rd("prio_badv", 5'd8, 32'hCAFE_0000);
        check_rd("prio_cause", 5'd13, 32'h0000_0014);
        check("prio_epc", epc_out, 32'h0000_1000);

        // ---- reset mid-operation ----
        wb_ex = 1'b1; wb_excode = 5'd4; wb_bd = 1'b0; wb_pc = 32'h44; wb_badvaddr = 32'h99;
        #2 reset = 1'b1;
        model_reset();
        check_rd("mid_rst_status", 5'd12, 32'h0040_0000);
        check_rd("mid_rst_epc", 5'd14, 32'h0);
        check_rd("mid_rst_badv", 5'd8, 32'h0);
        wb_ex = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_int", {31'b0, int_req}, 32'h0);
        reset = 1'b0;
        tick();
        check_rd("post_rst_status", 5'd12, 32'h0040_0000);
        check_rd("post_rst_cause", 5'd13, TIMER ? 32'h4000_8000 : 32'h0);
        check_rd("post_rst_epc", 5'd14, 32'h0);

        // ---- random traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            wb_ex      = (r < 8) || (r >= 50 && r < 56);
            eret_flush = (r >= 8 && r < 16) || (r >= 50 && r < 53);
            mtc0_we    = (r >= 16 && r < 56);
            case ($urandom_range(0, 6))
                0: c0_waddr = 5'd8;
                1: c0_waddr = 5'd9;
                2: c0_waddr = 5'd11;
                3: c0_waddr = 5'd12;
                4: c0_waddr = 5'd13;
                5: c0_waddr = 5'd14;
                default: c0_waddr = 5'($urandom);
            endcase
            c0_wdata = $urandom;
            if (c0_waddr == 5'd11 && $urandom_range(0, 1) == 1)
                c0_wdata = model_count() + $urandom_range(0, 20);
            if (c0_waddr == 5'd9 && $urandom_range(0, 3) == 0)
                c0_wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
            wb_excode   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            wb_bd       = 1'($urandom);
            wb_pc       = $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom;
            wb_badvaddr = $urandom;
            if ($urandom_range(0, 9) == 0) ext_int_in = 6'($urandom);
            tick();
            wb_ex = 1'b0; eret_flush = 1'b0; mtc0_we = 1'b0;
            rd(5'($urandom), d);
            check("rand_rdata", d, model_read(c0_raddr));
            check("rand_exl", {31'b0, status_exl}, {31'b0, m_exl});
            check("rand_epc_out", epc_out, m_epc);
            check("rand_int_req", {31'b0, int_req}, {31'b0, m_int_req});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
